cc1200_cmd_seq: RTL and testbench
=================================

// Module: cc1200_cmd_seq
// PURPOSE
//  Register-access command sequencer between the APB register file and the byte-level CC1200 SPI engine.
//  - Takes one command: R/W, normal or extended address space, address, byte count.
//  - Builds the CC1200 header byte, or the 0x2F extended-access prefix plus the address byte.
//  - Paces write data from a tx stream and buffers read data in an internal RX FIFO.
//  - Captures the chip status byte returned during the header byte.
// PARAMETERS
//  FIFO_DEPTH   16    RX FIFO entries, power of 2, >=2
//  TIMEOUT_CYC  4096  watchdog limit in clk cycles (used only with CC1200_SEQ_TIMEOUT_EN)
// PORTS
//  clk           in   1  system clock
//  rstn          in   1  asynchronous active-low reset
//  cmd_valid     in   1  command request
//  cmd_ready     out  1  high in IDLE; command accepted when cmd_valid&cmd_ready
//  cmd_rw        in   1  1=read, 0=write
//  cmd_ext       in   1  1=extended register space (0x2F prefix)
//  cmd_addr      in   8  register/strobe address; [5:0] used when cmd_ext=0
//  cmd_len       in   8  data bytes, 0..255; 0=header only (strobe)
//  tx_data       in   8  write data byte
//  tx_valid      in   1  tx_data valid
//  tx_ready      out  1  1-cycle pulse when tx_data is consumed
//  rx_data       out  8  RX FIFO head
//  rx_valid      out  1  RX FIFO not empty
//  rx_ready      in   1  pop RX FIFO when rx_valid&rx_ready
//  status        out  8  last chip status byte
//  status_valid  out  1  1-cycle pulse when status updates
//  busy          out  1  state!=IDLE
//  done          out  1  1-cycle pulse at command completion
//  err           out  1  1-cycle pulse on watchdog abort (tied 0 without macro)
//  spi_start     out  1  1-cycle pulse, launch one byte
//  spi_dout      out  8  byte to send, stable from spi_start until spi_done
//  spi_last      out  1  release CS_n after this byte, valid with spi_start
//  spi_busy      in   1  engine busy
//  spi_done      in   1  1-cycle pulse, byte finished, spi_din valid
//  spi_din       in   8  byte received
// BEHAVIOUR
//  Reset: all outputs 0 except cmd_ready=1; state=IDLE; RX FIFO empty; status=8'h00.
//  Header byte:
//   - burst = (cmd_len>1).
//   - cmd_ext=0: {rw, burst, addr[5:0]}.
//   - cmd_ext=1: {rw, burst, 6'h2F}, followed by cmd_addr.
//  States:
//   - IDLE -> HDR on accept. Latch all cmd_* fields and the length counter.
//   - HDR -> EXT (ext) | DATA (len>0) | FIN.
//   - EXT -> DATA (len>0) | FIN.
//   - DATA loops until the counter reaches 0 -> FIN.
//   - FIN -> IDLE: done pulse.
//  Byte issue:
//   - Each state issues a byte only when spi_busy=0, then waits for spi_done.
//   - At most one byte in flight.
//   - First spi_start comes 1 cycle after accept; next spi_start is >=1 cycle after spi_done.
//   - spi_last=1 only on the final byte of the command. CS_n is held across all stalls.
//  Write DATA:
//   - Waits for tx_valid; spi_dout=tx_data.
//   - tx_ready pulses in the spi_start cycle.
//  Read DATA:
//   - spi_dout=8'h00.
//   - Issue only when the FIFO has space: rx_count<FIFO_DEPTH, counting a push in flight.
//   - Push spi_din on spi_done.
//  Status: on the header byte's spi_done, status<=spi_din; status_valid pulses the next cycle.
//  Counters: length counter is 8-bit, no wrap (len=0 never enters DATA).
//  FIFO pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally.
//  Simultaneous push and pop: count unchanged, data order kept. Pop when empty is ignored.
//  cmd_valid outside IDLE is ignored (cmd_ready=0).
//  rx FIFO contents persist across commands; only reset clears them.
//  spi_done in IDLE is ignored.
//  Reset mid-operation: immediate return to reset state; in-flight byte discarded.
// CONFIGURATION
//  Macro: CC1200_SEQ_TIMEOUT_EN.
//  Defined:
//   - A counter starts at spi_start and clears on spi_done.
//   - Reaching TIMEOUT_CYC: err and done pulse together, state->IDLE, RX FIFO kept.
//   - Later stray spi_done is ignored.
//  Undefined: no counter, err tied 0, a byte waits for spi_done indefinitely.
// TESTING
//  1 Write, ext=0, addr 0x0A, len1, tx 0x5A -> bytes 0x0A, 0x5A; spi_last on 2nd only; status=din of byte1; done.
//  2 Burst read, addr 0x10, len4; model returns 0x11..0x14 -> header 0xD0, 4x 0x00; rx_data 0x11,0x12,0x13,0x14 in order.
//  3 Ext read, addr 0x8F, len1 -> bytes 0xAF, 0x8F, 0x00; 1 rx word; spi_last on 3rd.
//  4 Strobe 0x36, len0 -> single byte 0x36 with spi_last=1; status_valid; done; no tx_ready, no rx push.
//  5 Read len20, FIFO_DEPTH=16, rx_ready=0 -> exactly 16 pushes, then no spi_start.
//    Release rx_ready -> remaining 4 bytes complete; 20 words in order.
//  6 Write len3, tx_valid gaps of 10 cycles -> spi_start waits for tx_valid.
//    rstn pulse mid-burst -> all outputs at reset values, cmd_ready=1.
//    With macro, TIMEOUT_CYC=64 and spi_done withheld -> err+done at cycle 64.

Source files
------------

// File: rtl/cc1200_cmd_seq_if.sv
// Command, TX/RX stream, status and SPI byte-engine signals of cc1200_cmd_seq.
// slave = the sequencer; master = the register file / SPI engine side.
interface cc1200_cmd_seq_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_rw;
    logic       cmd_ext;
    logic [7:0] cmd_addr;
    logic [7:0] cmd_len;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] status;
    logic       status_valid;
    logic       busy;
    logic       done;
    logic       err;
    logic       spi_start;
    logic [7:0] spi_dout;
    logic       spi_last;
    logic       spi_busy;
    logic       spi_done;
    logic [7:0] spi_din;

    modport slave (
        input  cmd_valid, cmd_rw, cmd_ext, cmd_addr, cmd_len,
        input  tx_data, tx_valid, rx_ready,
        input  spi_busy, spi_done, spi_din,
        output cmd_ready, tx_ready, rx_data, rx_valid,
        output status, status_valid, busy, done, err,
        output spi_start, spi_dout, spi_last
    );

    modport master (
        output cmd_valid, cmd_rw, cmd_ext, cmd_addr, cmd_len,
        output tx_data, tx_valid, rx_ready,
        output spi_busy, spi_done, spi_din,
        input  cmd_ready, tx_ready, rx_data, rx_valid,
        input  status, status_valid, busy, done, err,
        input  spi_start, spi_dout, spi_last
    );
endinterface

// File: rtl/cc1200_cmd_seq.sv
// CC1200 register-access sequencer: header/extended prefix, tx pacing, RX FIFO, status capture.
// Define CC1200_SEQ_TIMEOUT_EN to enable the per-byte watchdog (TIMEOUT_CYC cycles).
module cc1200_cmd_seq #(
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic            clk,
    input  logic            rstn,
    cc1200_cmd_seq_if.slave bus
);
    localparam int unsigned AW    = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH = (AW + 1)'(FIFO_DEPTH);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of 2 and at least 2");
    end
    if (TIMEOUT_CYC < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be at least 2");
    end

    typedef enum logic [2:0] {S_IDLE, S_HDR, S_EXT, S_DATA, S_FIN} state_t;

    state_t      state_q, state_d;
    logic        inflight_q, inflight_d;
    logic        rw_q, rw_d;
    logic        ext_q, ext_d;
    logic [7:0]  addr_q, addr_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  dout_q, dout_d;
    logic [7:0]  status_q, status_d;
    logic        status_valid_q, status_valid_d;
    logic [AW:0] wptr_q, wptr_d;
    logic [AW:0] rptr_q, rptr_d;
    logic [7:0]  mem_q [FIFO_DEPTH];

    logic [AW:0] rx_count;
    logic        rx_valid;
    logic [7:0]  hdr_byte;
    logic [7:0]  cur_byte;
    logic        cur_last;
    logic        can_issue;
    logic        start;
    logic        byte_done;
    logic        push;
    logic        pop;
    logic        abort;

    assign rx_count  = wptr_q - rptr_q;
    assign rx_valid  = (rx_count != '0);
    assign pop       = rx_valid && bus.rx_ready;
    assign byte_done = inflight_q && bus.spi_done;

    // Byte offered by the current state and whether it may launch now.
    always_comb begin
        hdr_byte  = {rw_q, (cnt_q > 8'd1), (ext_q ? 6'h2F : addr_q[5:0])};
        cur_byte  = '0;
        cur_last  = 1'b0;
        can_issue = 1'b0;
        case (state_q)
            S_HDR: begin
                cur_byte  = hdr_byte;
                cur_last  = !ext_q && (cnt_q == 8'd0);
                can_issue = 1'b1;
            end
            S_EXT: begin
                cur_byte  = addr_q;
                cur_last  = (cnt_q == 8'd0);
                can_issue = 1'b1;
            end
            S_DATA: begin
                cur_last = (cnt_q == 8'd1);
                if (rw_q) begin
                    // Only issued with nothing in flight, so rx_count already includes every push.
                    can_issue = (rx_count < DEPTH);
                end else begin
                    cur_byte  = bus.tx_data;
                    can_issue = bus.tx_valid;
                end
            end
            default: ;
        endcase
        start = can_issue && !inflight_q && !bus.spi_busy;
    end

    always_comb begin
        state_d        = state_q;
        inflight_d     = inflight_q;
        rw_d           = rw_q;
        ext_d          = ext_q;
        addr_d         = addr_q;
        cnt_d          = cnt_q;
        dout_d         = dout_q;
        status_d       = status_q;
        status_valid_d = 1'b0;
        push           = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    rw_d    = bus.cmd_rw;
                    ext_d   = bus.cmd_ext;
                    addr_d  = bus.cmd_addr;
                    cnt_d   = bus.cmd_len;
                    state_d = S_HDR;
                end
            end
            S_HDR, S_EXT, S_DATA: begin
                if (start) begin
                    inflight_d = 1'b1;
                    dout_d     = cur_byte;
                end
                if (byte_done) begin
                    inflight_d = 1'b0;
                    if (state_q == S_HDR) begin
                        status_d       = bus.spi_din;
                        status_valid_d = 1'b1;
                        if (ext_q)              state_d = S_EXT;
                        else if (cnt_q != 8'd0) state_d = S_DATA;
                        else                    state_d = S_FIN;
                    end else if (state_q == S_EXT) begin
                        state_d = (cnt_q != 8'd0) ? S_DATA : S_FIN;
                    end else begin
                        push  = rw_q;
                        cnt_d = cnt_q - 8'd1;
                        if (cnt_q == 8'd1) state_d = S_FIN;
                    end
                end
            end
            S_FIN: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (abort) begin
            state_d    = S_IDLE;
            inflight_d = 1'b0;
        end
        wptr_d = wptr_q + {{AW{1'b0}}, push};
        rptr_d = rptr_q + {{AW{1'b0}}, pop};
    end

`ifdef CC1200_SEQ_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] to_cnt_q, to_cnt_d;

    // Counts cycles since spi_start; the start cycle itself is cycle 0.
    always_comb begin
        to_cnt_d = '0;
        if (start)                                     to_cnt_d = TW'(1);
        else if (inflight_q && !byte_done && !abort)   to_cnt_d = to_cnt_q + TW'(1);
    end

    assign abort = inflight_q && !bus.spi_done && (to_cnt_q == TW'(TIMEOUT_CYC));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) to_cnt_q <= '0;
        else       to_cnt_q <= to_cnt_d;
    end
`else
    assign abort = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q        <= S_IDLE;
            inflight_q     <= 1'b0;
            rw_q           <= 1'b0;
            ext_q          <= 1'b0;
            addr_q         <= '0;
            cnt_q          <= '0;
            dout_q         <= '0;
            status_q       <= '0;
            status_valid_q <= 1'b0;
            wptr_q         <= '0;
            rptr_q         <= '0;
        end else begin
            state_q        <= state_d;
            inflight_q     <= inflight_d;
            rw_q           <= rw_d;
            ext_q          <= ext_d;
            addr_q         <= addr_d;
            cnt_q          <= cnt_d;
            dout_q         <= dout_d;
            status_q       <= status_d;
            status_valid_q <= status_valid_d;
            wptr_q         <= wptr_d;
            rptr_q         <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q[AW-1:0]] <= bus.spi_din;
    end

    assign bus.cmd_ready    = (state_q == S_IDLE);
    assign bus.busy         = (state_q != S_IDLE);
    assign bus.done         = (state_q == S_FIN) || abort;
    assign bus.err          = abort;
    assign bus.spi_start    = start;
    assign bus.spi_dout     = inflight_q ? dout_q : (start ? cur_byte : '0);
    assign bus.spi_last     = start && cur_last;
    assign bus.tx_ready     = start && (state_q == S_DATA) && !rw_q;
    assign bus.rx_valid     = rx_valid;
    assign bus.rx_data      = rx_valid ? mem_q[rptr_q[AW-1:0]] : '0;
    assign bus.status       = status_q;
    assign bus.status_valid = status_valid_q;
endmodule

// File: tb/tb_cc1200_cmd_seq.sv
// Self-checking bench for cc1200_cmd_seq: command table plus FIFO-full, tx-gap, reset and watchdog sequences.
// SPI engine, tx source and rx sink are behavioural models feeding scoreboard queues.
module tb_cc1200_cmd_seq;
    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    cc1200_cmd_seq_if bus ();

    cc1200_cmd_seq #(.FIFO_DEPTH(16), .TIMEOUT_CYC(64)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    typedef struct {
        bit         rw;
        bit         ext;
        logic [7:0] addr;
        logic [7:0] len;
        logic [7:0] din_base;
        logic [7:0] exp_hdr;
    } vec_t;

    vec_t vt [8];

    int errors    = 0;
    int checks    = 0;
    int cyc       = 0;
    int start_cnt = 0;
    int err_cnt   = 0;
    int start_cyc [$];
    logic [8:0] exp_spi [$];
    logic [7:0] din_q   [$];
    logic [7:0] exp_rx  [$];
    logic [7:0] exp_st  [$];
    logic [7:0] tx_q    [$];
    int lat      = 3;
    bit withhold = 1'b0;
    bit rx_en    = 1'b1;
    int tx_gap   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic miss(input string name, input logic [31:0] act);
        checks++;
        errors++;
        $display("FAIL %s: got 0x%0h, expected nothing (cycle %0d)", name, act, cyc);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.err === 1'b1) err_cnt++;
        if (bus.status_valid === 1'b1) begin
            if (exp_st.size() == 0) miss("status_unexpected", bus.status);
            else                    chk("status_byte", bus.status, exp_st.pop_front());
        end
    end

    // SPI byte engine model
    initial begin
        logic [7:0] b;
        logic       l;
        bus.spi_busy = 1'b0;
        bus.spi_done = 1'b0;
        bus.spi_din  = '0;
        forever begin
            @(negedge clk);
            if (bus.spi_start === 1'b1) begin
                b = bus.spi_dout;
                l = bus.spi_last;
                start_cnt++;
                start_cyc.push_back(cyc);
                if (exp_spi.size() == 0) miss("spi_unexpected", {l, b});
                else                     chk("spi_byte_last", {l, b}, exp_spi.pop_front());
                @(posedge clk);
                #1 bus.spi_busy = 1'b1;
                for (int i = 0; (i < lat) || (withhold && i < 5000); i++) begin
                    @(negedge clk);
                    if (rstn && bus.busy) chk("spi_dout_stable", bus.spi_dout, b);
                end
                @(posedge clk);
                #1;
                bus.spi_done = 1'b1;
                bus.spi_din  = (din_q.size() != 0) ? din_q.pop_front() : 8'hEE;
                @(posedge clk);
                #1;
                bus.spi_done = 1'b0;
                bus.spi_busy = 1'b0;
            end
        end
    end

    // TX stream source with optional gap after each consumed byte
    initial begin
        bit consumed;
        int gap;
        gap = 0;
        bus.tx_valid = 1'b0;
        bus.tx_data  = '0;
        forever begin
            @(negedge clk);
            consumed = bus.tx_valid && bus.tx_ready;
            if (bus.tx_ready === 1'b1) chk("tx_ready_in_start", bus.spi_start, 1'b1);
            @(posedge clk);
            #1;
            if (consumed) begin
                if (tx_q.size() != 0) void'(tx_q.pop_front());
                bus.tx_valid = 1'b0;
                gap = tx_gap;
            end
            if (tx_q.size() == 0) begin
                bus.tx_valid = 1'b0;
            end else if (!bus.tx_valid) begin
                if (gap > 0) gap--;
                else begin
                    bus.tx_valid = 1'b1;
                    bus.tx_data  = tx_q[0];
                end
            end
        end
    end

    // RX sink
    initial begin
        bus.rx_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.rx_valid && bus.rx_ready) begin
                if (exp_rx.size() == 0) miss("rx_unexpected", bus.rx_data);
                else                    chk("rx_data_order", bus.rx_data, exp_rx.pop_front());
            end
            @(posedge clk);
            #1 bus.rx_ready = rx_en;
        end
    end

    initial begin
        #500000;
        checks++;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    task automatic check_reset_outs(input string tag);
        chk({tag, "_cmd_ready"},    bus.cmd_ready,    1'b1);
        chk({tag, "_busy"},         bus.busy,         1'b0);
        chk({tag, "_done"},         bus.done,         1'b0);
        chk({tag, "_err"},          bus.err,          1'b0);
        chk({tag, "_spi_start"},    bus.spi_start,    1'b0);
        chk({tag, "_spi_dout"},     bus.spi_dout,     8'h00);
        chk({tag, "_spi_last"},     bus.spi_last,     1'b0);
        chk({tag, "_tx_ready"},     bus.tx_ready,     1'b0);
        chk({tag, "_rx_valid"},     bus.rx_valid,     1'b0);
        chk({tag, "_rx_data"},      bus.rx_data,      8'h00);
        chk({tag, "_status"},       bus.status,       8'h00);
        chk({tag, "_status_valid"}, bus.status_valid, 1'b0);
    endtask

    task automatic issue(input bit rw, input bit ext, input logic [7:0] addr, input logic [7:0] len);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b1;
        bus.cmd_rw    = rw;
        bus.cmd_ext   = ext;
        bus.cmd_addr  = addr;
        bus.cmd_len   = len;
        @(negedge clk);
        chk("cmd_ready_idle", bus.cmd_ready, 1'b1);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_rw    = ~rw;
        bus.cmd_ext   = ~ext;
        bus.cmd_addr  = 8'($urandom);
        bus.cmd_len   = 8'($urandom);
        @(negedge clk);
        chk("first_start_latency", bus.spi_start, 1'b1);
        chk("busy_after_accept", bus.busy, 1'b1);
    endtask

    task automatic wait_done(input string name, input int limit);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < limit && !seen; n++) begin
            @(negedge clk);
            if (bus.done === 1'b1) seen = 1'b1;
        end
        chk(name, seen, 1'b1);
    endtask

    task automatic prep_vec(input vec_t v, input logic [7:0] st);
        logic [7:0] b;
        logic       lst;
        exp_spi.push_back({(!v.ext && v.len == 8'd0), v.exp_hdr});
        din_q.push_back(st);
        exp_st.push_back(st);
        if (v.ext) begin
            exp_spi.push_back({(v.len == 8'd0), v.addr});
            din_q.push_back(8'h5C);
        end
        for (int i = 0; i < int'(v.len); i++) begin
            lst = (i == int'(v.len) - 1);
            if (v.rw) begin
                exp_spi.push_back({lst, 8'h00});
                din_q.push_back(v.din_base + 8'(i));
                exp_rx.push_back(v.din_base + 8'(i));
            end else begin
                b = 8'($urandom);
                tx_q.push_back(b);
                exp_spi.push_back({lst, b});
                din_q.push_back(8'($urandom));
            end
        end
    endtask

    task automatic check_empty(input string tag);
        chk({tag, "_spi_left"},    exp_spi.size(), 0);
        chk({tag, "_rx_left"},     exp_rx.size(),  0);
        chk({tag, "_status_left"}, exp_st.size(),  0);
    endtask

    task automatic run_vec(input vec_t v, input logic [7:0] st, input bit poke);
        prep_vec(v, st);
        issue(v.rw, v.ext, v.addr, v.len);
        if (poke) begin
            for (int k = 0; k < 4; k++) begin
                @(posedge clk);
                #1;
                bus.cmd_valid = 1'b1;
                bus.cmd_len   = 8'd1;
                @(negedge clk);
                chk("cmd_ready_while_busy", bus.cmd_ready, 1'b0);
            end
            @(posedge clk);
            #1 bus.cmd_valid = 1'b0;
        end
        wait_done("done_vec", 3000);
        repeat (4) @(negedge clk);
        check_empty("vec");
        chk("status_reg", bus.status, st);
    endtask

    initial begin
        vec_t v;
        bit   seen;
        int   s0;
        int   n;
        int   exp_err;

        bus.cmd_valid = 1'b0;
        bus.cmd_rw    = 1'b0;
        bus.cmd_ext   = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_len   = '0;

        vt[0] = '{rw: 1'b0, ext: 1'b0, addr: 8'h0A, len: 8'd1, din_base: 8'h00, exp_hdr: 8'h0A};
        vt[1] = '{rw: 1'b1, ext: 1'b0, addr: 8'h10, len: 8'd4, din_base: 8'h11, exp_hdr: 8'hD0};
        vt[2] = '{rw: 1'b1, ext: 1'b1, addr: 8'h8F, len: 8'd1, din_base: 8'h60, exp_hdr: 8'hAF};
        vt[3] = '{rw: 1'b0, ext: 1'b0, addr: 8'h36, len: 8'd0, din_base: 8'h00, exp_hdr: 8'h36};
        vt[4] = '{rw: 1'b0, ext: 1'b1, addr: 8'h12, len: 8'd3, din_base: 8'h00, exp_hdr: 8'h6F};
        vt[5] = '{rw: 1'b1, ext: 1'b0, addr: 8'hFF, len: 8'd2, din_base: 8'hF0, exp_hdr: 8'hFF};
        vt[6] = '{rw: 1'b0, ext: 1'b1, addr: 8'h00, len: 8'd0, din_base: 8'h00, exp_hdr: 8'h2F};
        vt[7] = '{rw: 1'b1, ext: 1'b0, addr: 8'h3D, len: 8'd0, din_base: 8'h00, exp_hdr: 8'hBD};

        repeat (2) @(negedge clk);
        check_reset_outs("por");
        @(posedge clk);
        #1 rstn = 1'b1;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 8; i++) run_vec(vt[i], 8'h80 + 8'(i * 9), (i == 1));

        // RX FIFO full: read of 20 with the sink stalled
        rx_en = 1'b0;
        repeat (2) @(posedge clk);
        v = '{rw: 1'b1, ext: 1'b0, addr: 8'h00, len: 8'd20, din_base: 8'h40, exp_hdr: 8'hC0};
        prep_vec(v, 8'h4D);
        s0 = start_cnt;
        issue(v.rw, v.ext, v.addr, v.len);
        repeat (200) @(negedge clk);
        chk("starts_until_full", start_cnt - s0, 17);
        chk("rx_valid_full", bus.rx_valid, 1'b1);
        repeat (40) @(negedge clk);
        chk("starts_while_full", start_cnt - s0, 17);
        chk("busy_while_full", bus.busy, 1'b1);
        rx_en = 1'b1;
        wait_done("done_fifo_full", 3000);
        repeat (6) @(negedge clk);
        check_empty("fifo_full");

        // Write with 10-cycle tx gaps
        tx_gap = 10;
        v = '{rw: 1'b0, ext: 1'b0, addr: 8'h05, len: 8'd3, din_base: 8'h00, exp_hdr: 8'h45};
        prep_vec(v, 8'h21);
        s0 = start_cyc.size();
        issue(v.rw, v.ext, v.addr, v.len);
        wait_done("done_tx_gap", 3000);
        repeat (4) @(negedge clk);
        chk("tx_gap_start_count", start_cyc.size() - s0, 4);
        if (start_cyc.size() >= s0 + 4) begin
            chk("tx_gap_wait_1", (start_cyc[s0 + 2] - start_cyc[s0 + 1]) >= 11, 1'b1);
            chk("tx_gap_wait_2", (start_cyc[s0 + 3] - start_cyc[s0 + 2]) >= 11, 1'b1);
        end
        check_empty("tx_gap");
        tx_gap = 0;

        // Leave two words in the FIFO, then reset in the middle of a write burst
        rx_en = 1'b0;
        repeat (2) @(posedge clk);
        v = '{rw: 1'b1, ext: 1'b0, addr: 8'h21, len: 8'd2, din_base: 8'h90, exp_hdr: 8'hE1};
        prep_vec(v, 8'h17);
        issue(v.rw, v.ext, v.addr, v.len);
        wait_done("done_rx_hold", 3000);
        repeat (3) @(negedge clk);
        chk("rx_held_valid", bus.rx_valid, 1'b1);
        chk("rx_held_head", bus.rx_data, 8'h90);

        v = '{rw: 1'b0, ext: 1'b1, addr: 8'h44, len: 8'd3, din_base: 8'h00, exp_hdr: 8'h6F};
        prep_vec(v, 8'h2B);
        s0 = start_cnt;
        issue(v.rw, v.ext, v.addr, v.len);
        seen = 1'b0;
        for (int k = 0; k < 300 && !seen; k++) begin
            @(negedge clk);
            if (start_cnt >= s0 + 4) seen = 1'b1;
        end
        chk("mid_burst_reached", seen, 1'b1);
        @(posedge clk);
        #1 rstn = 1'b0;
        @(negedge clk);
        check_reset_outs("mid_reset");
        for (int k = 0; k < 50 && bus.spi_busy; k++) @(negedge clk);
        exp_spi.delete();
        din_q.delete();
        exp_rx.delete();
        exp_st.delete();
        tx_q.delete();
        @(posedge clk);
        #1 rstn = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_reset_cmd_ready", bus.cmd_ready, 1'b1);
        chk("post_reset_busy", bus.busy, 1'b0);
        chk("post_reset_rx_valid", bus.rx_valid, 1'b0);
        rx_en = 1'b1;
        run_vec(vt[3], 8'h5A, 1'b0);

        exp_err = 0;
`ifdef CC1200_SEQ_TIMEOUT_EN
        // Watchdog: header byte never completes
        withhold = 1'b1;
        exp_spi.push_back({1'b1, 8'h36});
        din_q.push_back(8'h99);
        issue(1'b0, 1'b0, 8'h36, 8'd0);
        n = 0;
        seen = 1'b0;
        while (!seen && n < 200) begin
            @(negedge clk);
            n++;
            if (bus.err === 1'b1) seen = 1'b1;
        end
        chk("timeout_seen", seen, 1'b1);
        chk("timeout_cycle", n, 64);
        chk("timeout_done_with_err", bus.done, 1'b1);
        @(negedge clk);
        chk("timeout_cmd_ready", bus.cmd_ready, 1'b1);
        withhold = 1'b0;
        repeat (lat + 6) @(negedge clk);
        chk("timeout_stray_done_idle", bus.busy, 1'b0);
        chk("timeout_status_kept", bus.status, 8'h5A);
        check_empty("timeout");
        exp_err = 1;
`endif
        chk("err_pulse_count", err_cnt, exp_err);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
